mixed_edge_event_unit: RTL



---
 rtl/mixed_edge_pkg.sv | 30 +++
 rtl/mixed_edge_event_unit_fifo.sv | 61 ++++++
 rtl/mixed_edge_event_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mixed_edge_pkg.sv
// Shared constants, arm-state encoding and event-record layout for mixed_edge_event_unit.
package mixed_edge_pkg;

    localparam int SRC_LVL  = 0;
    localparam int SRC_POS  = 1;
    localparam int SRC_NEG  = 2;
    localparam int TS_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2
    } arm_state_e;

    typedef struct packed {
        logic [2:0]          src;
        logic [TS_W_DEF-1:0] ts;
    } evt_rec_t;

    // s is the current sample, p the previous one; result is {neg,pos,lvl}
    function automatic logic [2:0] detect_mask(input logic [2:0] s, input logic [2:0] p);
        logic [2:0] m;
        m          = '0;
        m[SRC_LVL] = s[SRC_LVL] ^ p[SRC_LVL];
        m[SRC_POS] = s[SRC_POS] & ~p[SRC_POS];
        m[SRC_NEG] = ~s[SRC_NEG] & p[SRC_NEG];
        return m;
    endfunction

endpackage

// File: rtl/mixed_edge_event_unit_fifo.sv
// evt_fifo: synchronous valid/ready FIFO; a full FIFO still accepts a push when the head pops
// in the same cycle. No bypass: data written into an empty FIFO is visible the next cycle.
module evt_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         valid,
    output logic         full,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign valid   = (count_q != '0);
    assign full    = (count_q == FULL_CNT);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = valid && pop_ready;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mixed_edge_event_unit.sv
// Mixed-sensitivity event front-end: detection, arm FSM, counters, timestamp, event FIFO.
// Define EVT_SYNC_EN to add a 2-flop synchronizer on each input (one extra cycle of latency).
//
// state    | meaning
// ST_RESET | held in reset, pipeline content invalid
// ST_FILL  | input pipeline filling with real samples, detection masked
// ST_ARMED | detection live
module mixed_edge_event_unit
    import mixed_edge_pkg::*;
#(
    parameter int TS_W  = 16,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lvl_in,
    input  logic             pos_in,
    input  logic             neg_in,
    input  logic             clr_cnt,
    output logic             evt_pulse,
    output logic             tog_out,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [2:0]       evt_src,
    output logic [TS_W-1:0]  evt_ts,
    output logic [CNT_W-1:0] cnt_lvl,
    output logic [CNT_W-1:0] cnt_pos,
    output logic [CNT_W-1:0] cnt_neg,
    output logic             overflow
);
    localparam int REC_W = 3 + TS_W;
`ifdef EVT_SYNC_EN
    localparam logic [1:0] FILL_CYC = 2'd2;
`else
    localparam logic [1:0] FILL_CYC = 2'd1;
`endif

    arm_state_e       state_q, state_d;
    logic [1:0]       fill_q, fill_d;
    logic [2:0]       raw, s_q, s_d, p_q, p_d, mask;
    logic             evt;
    logic             pulse_q, pulse_d, tog_q, tog_d, ovf_q, ovf_d, push_q, push_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [REC_W-1:0] rec_q, rec_d, head;
    logic [CNT_W-1:0] cl_q, cl_d, cp_q, cp_d, cn_q, cn_d;
    logic             fifo_full;
`ifdef EVT_SYNC_EN
    logic [2:0]       sync_q;
`endif

    always_comb begin
        raw          = '0;
        raw[SRC_LVL] = lvl_in;
        raw[SRC_POS] = pos_in;
        raw[SRC_NEG] = neg_in;
    end

    always_comb begin
`ifdef EVT_SYNC_EN
        s_d = sync_q;
`else
        s_d = raw;
`endif
        p_d = s_q;
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_FILL;
                fill_d  = 2'd1;
            end
            ST_FILL: begin
                if (fill_q == FILL_CYC) state_d = ST_ARMED;
                else                    fill_d  = fill_q + 2'd1;
            end
            default: ;
        endcase
    end

    assign mask = (state_q == ST_ARMED) ? detect_mask(s_q, p_q) : 3'b000;
    assign evt  = |mask;

    // clr_cnt wins over a same-cycle increment; the event itself still toggles and pushes
    always_comb begin
        pulse_d = evt;
        tog_d   = tog_q ^ evt;
        ts_d    = ts_q + 1'b1;
        push_d  = evt;
        rec_d   = {mask, ts_q};
        cl_d    = (mask[SRC_LVL] && cl_q != '1) ? cl_q + 1'b1 : cl_q;
        cp_d    = (mask[SRC_POS] && cp_q != '1) ? cp_q + 1'b1 : cp_q;
        cn_d    = (mask[SRC_NEG] && cn_q != '1) ? cn_q + 1'b1 : cn_q;
        ovf_d   = ovf_q | (push_q & fifo_full & ~(evt_valid & evt_ready));
        if (clr_cnt) begin
            cl_d  = '0;
            cp_d  = '0;
            cn_d  = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            fill_q  <= '0;
            s_q     <= '0;
            p_q     <= '0;
            pulse_q <= 1'b0;
            tog_q   <= 1'b0;
            ts_q    <= '0;
            push_q  <= 1'b0;
            rec_q   <= '0;
            cl_q    <= '0;
            cp_q    <= '0;
            cn_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            s_q     <= s_d;
            p_q     <= p_d;
            pulse_q <= pulse_d;
            tog_q   <= tog_d;
            ts_q    <= ts_d;
            push_q  <= push_d;
            rec_q   <= rec_d;
            cl_q    <= cl_d;
            cp_q    <= cp_d;
            cn_q    <= cn_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef EVT_SYNC_EN
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= raw;
    end
`endif

    evt_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (rec_q),
        .pop_ready (evt_ready),
        .valid     (evt_valid),
        .full      (fifo_full),
        .head      (head)
    );

    assign evt_pulse = pulse_q;
    assign tog_out   = tog_q;
    assign evt_src   = head[REC_W-1 -: 3];
    assign evt_ts    = head[TS_W-1:0];
    assign cnt_lvl   = cl_q;
    assign cnt_pos   = cp_q;
    assign cnt_neg   = cn_q;
    assign overflow  = ovf_q;

endmodule
